// File: rtl/pdm_pkg.sv
// +----------------------------------------------------------------------------
// | Module      : pdm_pkg
// | Description : Shared state encoding and reset divider for the PDM clock
// |               generator.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pdm_state_t;

    // 50 MHz / (2 * (24 + 1)) = 1 MHz microphone clock
    localparam int c_DIV_RESET = 24;

endpackage : pdm_pkg

`default_nettype wire

// File: rtl/pdm_stb_delay.sv
// +----------------------------------------------------------------------------
// | Module      : pdm_stb_delay
// | Description : Resettable shift-register delay line for the edge strobes;
// |               DLY = 0 passes the strobes straight through.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module pdm_stb_delay #(
    parameter int DLY = 2,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DLY == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] r_pipe [DLY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DLY; k++) r_pipe[k] <= '0;
                end else begin
                    r_pipe[0] <= d;
                    for (int k = 1; k < DLY; k++) r_pipe[k] <= r_pipe[k-1];
                end
            end

            assign q = r_pipe[DLY-1];
        end
    endgenerate

endmodule : pdm_stb_delay

`default_nettype wire

// File: rtl/pdm_clk_gen.sv
// +----------------------------------------------------------------------------
// | Module      : pdm_clk_gen
// | Description : Divided PDM microphone clock with edge strobes and a
// |               period-safe divider reload. Define PDM_CLK_GEN_STB_DELAY_EN
// |               to delay rise_stb/fall_stb by STB_DLY cycles.
// | Revision    : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DIV_RESET = c_DIV_RESET,
    parameter int STB_DLY   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             busy
);

    pdm_state_t       r_state;
    pdm_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend_vld;
    logic             r_clk_out;
    logic             r_rise_stb;
    logic             r_fall_stb;
    logic             w_phase_end;
    logic             w_low_to_high;
    logic             w_accept;

    assign w_phase_end   = (r_cnt == r_div_cur);
    assign w_low_to_high = (r_state == LOW) && (w_state_nxt == HIGH);
    assign w_accept      = div_valid && !r_pend_vld;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en) w_state_nxt = HIGH;
            HIGH:    if (w_phase_end) w_state_nxt = LOW;
            LOW:     if (w_phase_end) w_state_nxt = en ? HIGH : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter restarts on every state entry, so it can never run past div_cur.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Reloads only land at a period boundary (or while idle), never mid-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cur  <= CNT_W'(DIV_RESET);
            r_div_pend <= '0;
            r_pend_vld <= 1'b0;
        end else if (r_pend_vld) begin
            if ((r_state == IDLE) || w_low_to_high) begin
                r_div_cur  <= r_div_pend;
                r_pend_vld <= 1'b0;
            end
        end else if (w_accept) begin
            r_div_pend <= div_in;
            r_pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_out  <= 1'b0;
            r_rise_stb <= 1'b0;
            r_fall_stb <= 1'b0;
        end else begin
            r_clk_out  <= (w_state_nxt == HIGH);
            r_rise_stb <= (w_state_nxt == HIGH) && (r_state != HIGH);
            r_fall_stb <= (w_state_nxt == LOW) && (r_state != LOW);
        end
    end

    assign clk_out   = r_clk_out;
    assign busy      = (r_state != IDLE);
    assign div_ready = !r_pend_vld;

`ifdef PDM_CLK_GEN_STB_DELAY_EN
    pdm_stb_delay #(
        .DLY (STB_DLY),
        .W   (2)
    ) u_stb_delay (
        .clk (clk),
        .rst (rst),
        .d   ({r_rise_stb, r_fall_stb}),
        .q   ({rise_stb, fall_stb})
    );
`else
    assign rise_stb = r_rise_stb;
    assign fall_stb = r_fall_stb;
`endif

endmodule : pdm_clk_gen

`default_nettype wire

// File: doc/pdm_clk_gen.md
PDM_CLK_GEN -- requirements
Module: pdm_clk_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, meaning the half-period counter and divider width in bits.
REQ-002 The block SHALL have parameter DIV_RESET, default 24, meaning the divider value after reset (50 MHz/(2*25) = 1 MHz clk_out).
REQ-003 The block SHALL have parameter STB_DLY, default 2, meaning the strobe delay in clk cycles; it is used only when PDM_CLK_GEN_STB_DELAY_EN is defined.
REQ-004 clk  in  1  system clock; the single clock of the block.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  run request for clk_out.
REQ-007 div_in  in  CNT_W  new divider; half-period = div_in+1 clk cycles.
REQ-008 div_valid  in  1  div_in offered.
REQ-009 div_ready  out  1  divider load accepted when div_valid&div_ready.
REQ-010 clk_out  out  1  registered divided clock to the MEMS microphones.
REQ-011 rise_stb  out  1  one-cycle pulse marking a clk_out rising edge (left-channel sample point).
REQ-012 fall_stb  out  1  one-cycle pulse marking a clk_out falling edge (right-channel sample point).
REQ-013 busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 The state machine SHALL have states IDLE, HIGH and LOW, and clk_out SHALL be 1 exactly in HIGH.
REQ-015 IDLE->HIGH SHALL occur on the first clk edge with en=1, and the counter SHALL be cleared on every state entry.
REQ-016 In HIGH and LOW the counter SHALL increment each cycle, and the state SHALL exit on the cycle after cnt==div_cur, giving div_cur+1 cycles per phase.
REQ-017 HIGH SHALL always go to LOW; LOW SHALL go to HIGH if en=1 at phase end, else to IDLE.
REQ-018 Deasserting en mid-phase SHALL not truncate the phase: the current phase completes, clk_out ends low, and no runt pulses occur.
REQ-019 Reasserting en before LOW ends SHALL continue clocking with no gap.
REQ-020 rise_stb SHALL be 1 in the first cycle of HIGH, and fall_stb SHALL be 1 in the first cycle of LOW; each strobe is exactly one cycle wide.
REQ-021 div_ready SHALL be 1 when no load is pending; an accepted value SHALL become pending, and div_ready SHALL be 0 while a load is pending.
REQ-022 A pending divider SHALL apply to div_cur on the LOW->HIGH or IDLE->HIGH transition, or on the next cycle if in IDLE, so a period never mixes divider values.
REQ-023 div_in=0 SHALL give clk_out=clk/2; div_in=2^CNT_W-1 SHALL give a half-period of 2^CNT_W cycles; the counter SHALL never wrap past div_cur.
REQ-024 When div_valid coincides with a LOW->HIGH transition, the old pending value (if any) SHALL apply now and the new offer SHALL wait (div_ready=0).

Reset
REQ-025 On rst the block SHALL immediately enter IDLE with clk_out=0, rise_stb=0, fall_stb=0, busy=0, div_ready=1, div_cur=DIV_RESET, no pending load and cnt=0.
REQ-026 Reset mid-phase SHALL force clk_out low asynchronously and discard any pending divider.

Configuration
REQ-027 With PDM_CLK_GEN_STB_DELAY_EN defined, rise_stb and fall_stb SHALL each be delayed by STB_DLY cycles through a shift register that is cleared on rst; STB_DLY=0 SHALL give no delay.
REQ-028 Without PDM_CLK_GEN_STB_DELAY_EN, the strobes SHALL be undelayed per REQ-020 and STB_DLY SHALL be ignored.

Structure
REQ-029 The state encoding enum (IDLE/HIGH/LOW) and the DIV_RESET default constant SHALL reside in the shared package pdm_pkg.
REQ-030 The strobe delay line SHALL be the sub-module pdm_stb_delay, instantiated only under PDM_CLK_GEN_STB_DELAY_EN.

Verification
REQ-031 Scenario: reset release, en=1, default divider -> clk_out period 50 cycles at 50% duty, and rise_stb/fall_stb each once per period.
REQ-032 Scenario: div_in=0 loaded in IDLE, then en=1 -> clk_out toggles every cycle and both strobes pulse alternately.
REQ-033 Scenario: div_in=3 offered mid-HIGH with divider 24 -> div_ready=0 until the next rising edge, the current period stays 50 cycles, and the next period is 8 cycles.
REQ-034 Scenario: en dropped 5 cycles into HIGH (divider 9) -> HIGH lasts 10 cycles and LOW lasts 10 cycles, then IDLE, busy=0, and no further rise_stb.
REQ-035 Scenario: rst asserted mid-HIGH -> clk_out=0 immediately, the pending divider is discarded, and div_cur=24 after release.
REQ-036 Scenario: with PDM_CLK_GEN_STB_DELAY_EN and STB_DLY=2 -> rise_stb fires 2 cycles after clk_out rises.
